// File: rtl/rstseq_pkg.sv
// Shared state encoding and counter-width helper for the reset sequencer.
// No logic; imported by rst_seq_watchdog.
package rstseq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_HOLD    = 3'd0;
  localparam state_t ST_STAGGER = 3'd1;
  localparam state_t ST_RUN     = 3'd2;
  localparam state_t ST_DONE    = 3'd3;
  localparam state_t ST_TIMEOUT = 3'd4;

  // Bits needed to count 0..value-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear (priority over enable) that sticks at all ones.
// One-cycle update latency; no backpressure.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !(&cnt)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/rst_seq_watchdog.sv
// Reset sequencer (hold, staggered per-domain release) plus run-cycle watchdog; outputs registered.
// Optional RSTSEQ_REQ_SYNC_EN puts rst_req through a 2-flop synchronizer (+2 cycles); no backpressure.
module rst_seq_watchdog
  import rstseq_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS    = 4,
  parameter int unsigned HOLD_CYCLES    = 25,
  parameter int unsigned STAGE_GAP      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 15000000,
  parameter int unsigned CNT_W          = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rst_req,
  input  logic                   halt_i,
  output logic [NUM_DOMAINS-1:0] dom_rst_o,
  output logic                   all_released_o,
  output logic [CNT_W-1:0]       cycle_cnt_o,
  output logic                   done_o,
  output logic                   timeout_o
);

  localparam int unsigned IDX_W  = cnt_width(NUM_DOMAINS);
  localparam int unsigned HOLD_W = cnt_width(HOLD_CYCLES);
  localparam int unsigned GAP_W  = cnt_width(STAGE_GAP);

  localparam logic [IDX_W-1:0]       LAST_IDX  = IDX_W'(NUM_DOMAINS - 1);
  localparam logic [HOLD_W-1:0]      HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0]       GAP_LAST  = GAP_W'((STAGE_GAP == 0) ? 0 : STAGE_GAP - 1);
  localparam logic [63:0]            TMO_LAST  = (TIMEOUT_CYCLES == 0) ? 64'd0
                                                 : 64'(TIMEOUT_CYCLES) - 64'd1;
  localparam logic [NUM_DOMAINS-1:0] DOM_ONE   = NUM_DOMAINS'(1);

  logic req;

`ifdef RSTSEQ_REQ_SYNC_EN
  logic req_meta;
  logic req_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_meta <= 1'b0;
      req_sync <= 1'b0;
    end else begin
      req_meta <= rst_req;
      req_sync <= req_meta;
    end
  end

  assign req = req_sync;
`else
  assign req = rst_req;
`endif

  state_t state;
  state_t state_nxt;

  logic [HOLD_W-1:0]      hold_cnt;
  logic [GAP_W-1:0]       gap_cnt;
  logic [CNT_W-1:0]       run_cnt;
  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       idx_nxt;
  logic [NUM_DOMAINS-1:0] dom_rst;
  logic                   done;
  logic                   tmo;

  logic hold_last;
  logic gap_last;
  logic stagger_last;
  logic tmo_hit;

  logic hold_en;
  logic hold_clr;
  logic gap_en;
  logic gap_clr;
  logic run_en;
  logic release_first;
  logic release_next;
  logic set_done;
  logic set_tmo;

  assign hold_last    = (hold_cnt == HOLD_LAST);
  assign gap_last     = (gap_cnt == GAP_LAST);
  // With a zero gap every domain is released on STAGGER entry.
  assign stagger_last = (STAGE_GAP == 0) || (idx == LAST_IDX);
  assign tmo_hit      = (TIMEOUT_CYCLES != 0) && (64'(run_cnt) == TMO_LAST);
  assign idx_nxt      = idx + IDX_W'(1);

  sat_counter #(.W(HOLD_W)) u_hold_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (hold_clr),
    .en    (hold_en),
    .cnt   (hold_cnt)
  );

  sat_counter #(.W(GAP_W)) u_gap_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (gap_clr),
    .en    (gap_en),
    .cnt   (gap_cnt)
  );

  sat_counter #(.W(CNT_W)) u_run_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (req),
    .en    (run_en),
    .cnt   (run_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_HOLD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (req) begin
      state_nxt = ST_HOLD;
    end else begin
      case (state)
        ST_HOLD:    if (hold_last)    state_nxt = ST_STAGGER;
        ST_STAGGER: if (stagger_last) state_nxt = ST_RUN;
        ST_RUN: begin
          // Halt takes priority over a coincident timeout.
          if (halt_i) begin
            state_nxt = ST_DONE;
          end else if (tmo_hit) begin
            state_nxt = ST_TIMEOUT;
          end
        end
        ST_DONE, ST_TIMEOUT: state_nxt = state;
        default:             state_nxt = ST_HOLD;
      endcase
    end
  end

  always_comb begin
    hold_en       = 1'b0;
    hold_clr      = 1'b1;
    gap_en        = 1'b0;
    gap_clr       = 1'b1;
    run_en        = 1'b0;
    release_first = 1'b0;
    release_next  = 1'b0;
    set_done      = 1'b0;
    set_tmo       = 1'b0;
    if (!req) begin
      case (state)
        ST_HOLD: begin
          hold_en       = 1'b1;
          hold_clr      = hold_last;
          release_first = hold_last;
        end
        ST_STAGGER: begin
          if (!stagger_last) begin
            gap_en       = 1'b1;
            gap_clr      = gap_last;
            release_next = gap_last;
          end
        end
        ST_RUN: begin
          run_en   = !halt_i && !tmo_hit;
          set_done = halt_i;
          set_tmo  = !halt_i && tmo_hit;
        end
        default: begin
          run_en = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dom_rst <= '1;
      idx     <= '0;
      done    <= 1'b0;
      tmo     <= 1'b0;
    end else if (req) begin
      dom_rst <= '1;
      idx     <= '0;
      done    <= 1'b0;
      tmo     <= 1'b0;
    end else begin
      if (release_first) begin
        idx     <= '0;
        dom_rst <= (STAGE_GAP == 0) ? '0 : (dom_rst & ~DOM_ONE);
      end
      if (release_next) begin
        idx     <= idx_nxt;
        dom_rst <= dom_rst & ~(DOM_ONE << idx_nxt);
      end
      if (set_done) begin
        done <= 1'b1;
      end
      if (set_tmo) begin
        tmo <= 1'b1;
      end
    end
  end

  assign dom_rst_o      = dom_rst;
  assign all_released_o = (state == ST_RUN);
  assign cycle_cnt_o    = run_cnt;
  assign done_o         = done;
  assign timeout_o      = tmo;

endmodule

// File: tb/tb_rst_seq_watchdog.sv
// Directed bench: power-on sequence, halt, timeout, mid-run request, edge parameters, async reset.
module tb_rst_seq_watchdog;

`ifdef RSTSEQ_REQ_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic req_a, halt_a, req_b, halt_b, req_c, halt_c;

  logic [3:0]  dom_a, dom_b;
  logic [0:0]  dom_c;
  logic        rel_a, rel_b, rel_c;
  logic [31:0] cnt_a, cnt_b;
  logic [3:0]  cnt_c;
  logic        done_a, done_b, done_c;
  logic        tmo_a, tmo_b, tmo_c;

  int tests = 0;
  int fails = 0;
  int k = 0;

  rst_seq_watchdog #(.NUM_DOMAINS(4), .HOLD_CYCLES(25), .STAGE_GAP(4),
                     .TIMEOUT_CYCLES(1000), .CNT_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .rst_req(req_a), .halt_i(halt_a),
    .dom_rst_o(dom_a), .all_released_o(rel_a), .cycle_cnt_o(cnt_a),
    .done_o(done_a), .timeout_o(tmo_a));

  rst_seq_watchdog #(.NUM_DOMAINS(4), .HOLD_CYCLES(25), .STAGE_GAP(4),
                     .TIMEOUT_CYCLES(50), .CNT_W(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .rst_req(req_b), .halt_i(halt_b),
    .dom_rst_o(dom_b), .all_released_o(rel_b), .cycle_cnt_o(cnt_b),
    .done_o(done_b), .timeout_o(tmo_b));

  rst_seq_watchdog #(.NUM_DOMAINS(1), .HOLD_CYCLES(1), .STAGE_GAP(0),
                     .TIMEOUT_CYCLES(0), .CNT_W(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .rst_req(req_c), .halt_i(halt_c),
    .dom_rst_o(dom_c), .all_released_o(rel_c), .cycle_cnt_o(cnt_c),
    .done_o(done_c), .timeout_o(tmo_c));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic tick_to(input int t);
    while (k < t) tick();
  endtask

  // Power-on release pattern for 4 domains, hold 25, gap 4.
  function automatic logic [3:0] dom_exp(input int n);
    if (n < 25)      return 4'hF;
    else if (n < 29) return 4'hE;
    else if (n < 33) return 4'hC;
    else if (n < 37) return 4'h8;
    else             return 4'h0;
  endfunction

  initial begin
    int r;
    int t0;
    int r2;
    rst_n = 1'b0;
    req_a = 1'b0; halt_a = 1'b0;
    req_b = 1'b0; halt_b = 1'b0;
    req_c = 1'b0; halt_c = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_dom_a",  dom_a,  4'hF);
    check("rst_rel_a",  rel_a,  0);
    check("rst_cnt_a",  cnt_a,  0);
    check("rst_done_a", done_a, 0);
    check("rst_tmo_a",  tmo_a,  0);
    check("rst_dom_c",  dom_c,  1);

    rst_n = 1'b1;
    k = 0;
    check("dom_a@0", dom_a, 4'hF);
    for (int i = 1; i <= 40; i++) begin
      tick();
      check($sformatf("dom_a@%0d", k), dom_a, dom_exp(k));
      check($sformatf("rel_a@%0d", k), rel_a, (k >= 38));
      check($sformatf("dom_b@%0d", k), dom_b, dom_exp(k));
      check($sformatf("dom_c@%0d", k), dom_c, 0);
      check($sformatf("rel_c@%0d", k), rel_c, (k >= 2));
    end
    check("cnt_a@40", cnt_a, 2);
    check("cnt_b@40", cnt_b, 2);
    check("cnt_c_sat@40", cnt_c, 15);

    // Mid-run request on dut_a, five cycles wide.
    tick_to(60);
    check("cnt_a@60", cnt_a, 22);
    req_a = 1'b1;
    tick_to(60 + L);
    check("req_pre_rel_a", rel_a, 1);
    tick_to(61 + L);
    check("req_dom_a", dom_a, 4'hF);
    check("req_cnt_a", cnt_a, 0);
    check("req_rel_a", rel_a, 0);
    tick_to(65);
    req_a = 1'b0;
    r = 65 + L;
    tick_to(r);
    check("req_held_dom_a", dom_a, 4'hF);

    // Timeout on dut_b at budget 50.
    tick_to(87);
    check("pre_tmo_cnt_b", cnt_b, 49);
    check("pre_tmo_b", tmo_b, 0);
    tick_to(88);
    check("tmo_b", tmo_b, 1);
    check("tmo_cnt_b", cnt_b, 49);
    check("tmo_done_b", done_b, 0);
    check("tmo_rel_b", rel_b, 0);
    tick_to(89);
    check("tmo_frozen_cnt_b", cnt_b, 49);
    check("tmo_dom_b", dom_b, 0);

    tick_to(r + 24); check("rr_dom_a+24", dom_a, 4'hF);
    tick_to(r + 25); check("rr_dom_a+25", dom_a, 4'hE);
    tick_to(r + 29); check("rr_dom_a+29", dom_a, 4'hC);
    tick_to(r + 33); check("rr_dom_a+33", dom_a, 4'h8);
    tick_to(r + 37); check("rr_dom_a+37", dom_a, 4'h0);
    check("rr_rel_a+37", rel_a, 0);
    tick_to(r + 38); check("rr_rel_a+38", rel_a, 1);
    check("rr_cnt_a+38", cnt_a, 0);

    // Halt on the saturated 4-bit counter.
    tick_to(140);
    check("sat_cnt_c@140", cnt_c, 15);
    halt_c = 1'b1;
    tick_to(141);
    halt_c = 1'b0;
    check("halt_done_c", done_c, 1);
    check("halt_cnt_c", cnt_c, 15);
    check("halt_tmo_c", tmo_c, 0);
    check("halt_rel_c", rel_c, 0);

    // Rerun dut_b; halt during HOLD must be ignored.
    tick_to(150);
    req_b = 1'b1;
    tick_to(151);
    req_b = 1'b0;
    t0 = 151 + L;
    tick_to(t0);
    check("rerun_dom_b", dom_b, 4'hF);
    check("rerun_tmo_b", tmo_b, 0);
    check("rerun_cnt_b", cnt_b, 0);
    check("rerun_rel_b", rel_b, 0);
    halt_b = 1'b1;
    tick_to(t0 + 3);
    halt_b = 1'b0;
    check("hold_halt_done_b", done_b, 0);
    check("hold_halt_dom_b", dom_b, 4'hF);

    // Halt on dut_a 100 cycles into RUN.
    tick_to(203 + L);
    check("pre_halt_cnt_a", cnt_a, 100);
    halt_a = 1'b1;
    tick_to(204 + L);
    halt_a = 1'b0;
    check("halt_done_a", done_a, 1);
    check("halt_cnt_a", cnt_a, 100);
    check("halt_tmo_a", tmo_a, 0);
    check("halt_rel_a", rel_a, 0);
    check("halt_dom_a", dom_a, 0);
    tick_to(209);
    check("halt_frozen_cnt_a", cnt_a, 100);

    tick_to(210);
    req_a = 1'b1;
    tick_to(211);
    req_a = 1'b0;
    r2 = 211 + L;

    // Halt and timeout in the same cycle: halt wins.
    tick_to(238 + L);
    check("tie_cnt_b", cnt_b, 49);
    check("tie_pre_tmo_b", tmo_b, 0);
    check("tie_rel_b", rel_b, 1);
    halt_b = 1'b1;
    tick_to(239 + L);
    halt_b = 1'b0;
    check("tie_done_b", done_b, 1);
    check("tie_tmo_b", tmo_b, 0);
    check("tie_frozen_cnt_b", cnt_b, 49);

    // Async reset pulse between edges while dut_a is mid-STAGGER.
    tick_to(r2 + 30);
    check("stag_dom_a", dom_a, 4'hC);
    #1 rst_n = 1'b0;
    #1;
    check("async_dom_a",  dom_a,  4'hF);
    check("async_rel_a",  rel_a,  0);
    check("async_dom_b",  dom_b,  4'hF);
    check("async_done_b", done_b, 0);
    check("async_cnt_b",  cnt_b,  0);
    check("async_done_c", done_c, 0);
    check("async_cnt_c",  cnt_c,  0);
    check("async_dom_c",  dom_c,  1);
    #2 rst_n = 1'b1;
    tick();
    check("post_async_dom_a", dom_a, 4'hF);
    check("post_async_rel_a", rel_a, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rst_seq_watchdog.md
Name: rst_seq_watchdog

Overview:
- Parametrised reset sequencer and run watchdog for the CPU top in simulation and on FPGA.
- Holds N reset domains for a programmable number of cycles after power-on or a button/software request.
- Releases the domains one at a time, in order, with a fixed gap between them.
- Counts run cycles and flags completion on a halt indication, or a timeout if the run exceeds a cycle budget.

Parameters:
- NUM_DOMAINS, 4: number of independent reset outputs; must be 1..16.
- HOLD_CYCLES, 25: cycles all domains stay asserted before the first release; must be >=1.
- STAGE_GAP, 4: cycles between successive domain releases; 0 means all domains release together.
- TIMEOUT_CYCLES, 15000000: run-cycle budget before timeout; 0 disables the timeout.
- CNT_W, 32: width of the run-cycle counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rst_req  in  1  button/software reset request, active-high, level or pulse
- halt_i  in  1  CPU reports program end, active-high
- dom_rst_o  out  NUM_DOMAINS  per-domain reset, active-high; bit 0 releases first
- all_released_o  out  1  high while state is RUN
- cycle_cnt_o  out  CNT_W  cycles spent in RUN
- done_o  out  1  sticky; set when halt_i is seen in RUN
- timeout_o  out  1  sticky; set when the budget is exhausted

Behaviour:
- Reset is asynchronous and active-low on rst_n. One clock, clk. All state is updated on the rising edge of clk.
- Values while rst_n=0:
  - dom_rst_o = all ones
  - all_released_o = 0
  - cycle_cnt_o = 0
  - done_o = 0
  - timeout_o = 0
  - state = HOLD
  - hold counter = 0
- HOLD:
  - All domains are asserted and the hold counter increments.
  - When the counter reaches HOLD_CYCLES-1, go to STAGGER with index = 0 and gap counter = 0.
  - Result: after rst_n deasserts, dom_rst_o[0] drops exactly HOLD_CYCLES cycles later.
- STAGGER:
  - On entry, clear dom_rst_o[index].
  - Each next domain drops STAGE_GAP cycles after the previous one.
  - If STAGE_GAP=0, every bit clears in the same cycle.
  - After the last bit clears, enter RUN on the next cycle.
- RUN:
  - cycle_cnt_o increments every cycle and saturates at all ones; it never wraps.
  - halt_i=1 sets done_o and moves to DONE.
  - If TIMEOUT_CYCLES!=0 and cycle_cnt_o == TIMEOUT_CYCLES-1, set timeout_o and move to TIMEOUT.
  - If halt_i and the timeout condition occur in the same cycle, halt wins: done_o=1, timeout_o=0.
- DONE / TIMEOUT:
  - Terminal states. The counter freezes.
  - dom_rst_o stays deasserted, so a bench can inspect state.
- rst_req, sampled in any state:
  - Forces state = HOLD and dom_rst_o = all ones on the next edge.
  - Clears the hold counter, cycle counter, done_o and timeout_o.
  - While rst_req stays high, the machine remains in HOLD with the hold counter held at 0.
  - Counting restarts only on the first cycle rst_req is low.
- halt_i is ignored outside RUN.
- rst_n low at any point aborts immediately to the reset values above. There is no partial state.

Optional Feature:
- Macro: RSTSEQ_REQ_SYNC_EN.
- When defined, rst_req passes through a two-flop synchronizer (reset to 0) before use. Every rst_req reaction is then delayed by 2 cycles.
- When not defined, rst_req is used directly. The caller guarantees it is synchronous to clk.

Decomposition:
- Shared package rstseq_pkg holds:
  - the state encoding localparams (HOLD=0, STAGGER=1, RUN=2, DONE=3, TIMEOUT=4, 3-bit)
  - a helper for clog2 of NUM_DOMAINS, HOLD_CYCLES and STAGE_GAP
- One sub-module, sat_counter: a parametrised-width counter with enable, synchronous clear and saturation.
  - Instantiated for the run counter.
  - Instantiated again for the hold and gap counters.

Test Plan:
- Power-on:
  - Stimulus: rst_n low for 3 cycles, then high, with NUM_DOMAINS=4, HOLD_CYCLES=25, STAGE_GAP=4.
  - Response: dom_rst_o = 1111 for cycles 0..24, then 1110 at cycle 25, 1100 at 29, 1000 at 33, 0000 at 37.
  - Response: all_released_o rises at cycle 38.
- Halt:
  - Stimulus: halt_i pulsed 100 cycles into RUN.
  - Response: done_o=1, cycle_cnt_o frozen at 100, timeout_o=0, state DONE.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=50, halt_i held low.
  - Response: timeout_o=1 with cycle_cnt_o=49.
  - Stimulus: halt_i=1 in that same cycle on a rerun.
  - Response: done_o=1, timeout_o=0.
- Mid-run request:
  - Stimulus: rst_req high for 5 cycles during RUN.
  - Response: dom_rst_o = 1111 on the next edge and counters cleared.
  - Response: the release sequence restarts 25 cycles after rst_req falls.
  - Repeat with RSTSEQ_REQ_SYNC_EN defined: every edge shifts by 2 cycles.
- Edge parameters:
  - Stimulus: STAGE_GAP=0, NUM_DOMAINS=1, HOLD_CYCLES=1.
  - Response: all domains drop together one cycle after rst_n rises.
  - Stimulus: CNT_W=4.
  - Response: cycle_cnt_o saturates at 15 and does not wrap.
- Async reset mid-STAGGER:
  - Stimulus: rst_n low for half a cycle between edges.
  - Response: outputs return to reset values immediately, without waiting for a clk edge.
